// File: rtl/mux_nx1_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mux_nx1_rr
//  Purpose  : N-channel, W-bit registered selector with a valid/ready
//             handshake on every channel. mode=0 forwards the channel named
//             by sel. mode=1 grants channels in round-robin order, starting
//             after the last channel granted. The output stream is one
//             register stage deep and carries the source channel tag.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             enable          - allows new grants (a held word still drains)
//             mode, sel       - 0 = fixed on sel, 1 = round-robin
//             in_data/in_valid/in_ready - packed per-channel input streams
//             out_data/out_chan/out_valid/out_ready - registered output
//  Revision : 1.0 - initial release
// ============================================================================
module mux_nx1_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Every index a SEL_W-bit value can name gets a slot; slots past the
    // last real channel read as "never valid". This makes an out-of-range
    // sel harmless without a separate range compare.
    localparam int               c_SLOTS   = 1 << SEL_W;
    localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]   w_slot_data [c_SLOTS];
    logic [c_SLOTS-1:0] w_slot_valid;

    logic [SEL_W-1:0]   w_rr_idx;
    logic [SEL_W-1:0]   w_cand;
    logic               w_rr_found;
    logic               w_fix_found;
    logic [SEL_W-1:0]   w_grant;
    logic               w_found;
    logic               w_load;

    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_chan;
    logic               r_out_valid;
    logic [SEL_W-1:0]   r_last_grant;

    generate
        for (genvar gi = 0; gi < c_SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_live
                assign w_slot_data[gi]  = in_data[gi*WIDTH +: WIDTH];
                assign w_slot_valid[gi] = in_valid[gi];
            end else begin : g_pad
                assign w_slot_data[gi]  = '0;
                assign w_slot_valid[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_fix_found = w_slot_valid[sel];

    // Round-robin search: walk last+1, last+2, ... modulo CHANNELS and keep
    // the first requester. The last step lands on last_grant itself, so a
    // lone requester is granted every cycle.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_cand = SEL_W'((int'(r_last_grant) + k) % CHANNELS);
            if (!w_rr_found && w_slot_valid[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    assign w_grant = mode ? w_rr_idx   : sel;
    assign w_found = mode ? w_rr_found : w_fix_found;

    // The output register can take a word when it is empty or being drained
    // this cycle. Reset suppresses the accept so in_ready stays 0 in a reset
    // cycle.
    assign w_load = ~rst & enable & (~r_out_valid | out_ready) & w_found;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = w_load && (w_grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_out_valid  <= 1'b0;
            r_last_grant <= c_LAST_CH;
        end else if (w_load) begin
            r_out_data   <= w_slot_data[w_grant];
            r_out_chan   <= w_grant;
            r_out_valid  <= 1'b1;
            r_last_grant <= w_grant;
        end else if (out_ready) begin
            // Drain with no replacement: data and tag keep their last values.
            r_out_valid  <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mux_nx1_rr
//  Purpose  : Self-checking bench for mux_nx1_rr. An 8-channel instance is
//             driven with directed and random stimulus and compared every
//             cycle against a behavioural model; a 6-channel instance
//             exercises out-of-range and last-channel fixed selects.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_rr;

    localparam int c_W = 8;
    localparam int c_N = 8;
    localparam int c_S = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             mode;
    logic [c_S-1:0]   sel;
    logic [c_N*c_W-1:0] in_data;
    logic [c_N-1:0]   in_valid;
    logic [c_N-1:0]   in_ready;
    logic [c_W-1:0]   out_data;
    logic [c_S-1:0]   out_chan;
    logic             out_valid;
    logic             out_ready;

    logic [c_S-1:0]   sel6;
    logic [6*c_W-1:0] in_data6;
    logic [5:0]       in_valid6;
    logic [5:0]       in_ready6;
    logic [c_W-1:0]   out_data6;
    logic [c_S-1:0]   out_chan6;
    logic             out_valid6;

    always #5 clk = ~clk;

    mux_nx1_rr #(.WIDTH(c_W), .CHANNELS(c_N), .SEL_W(c_S)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_nx1_rr #(.WIDTH(c_W), .CHANNELS(6), .SEL_W(c_S)) dut6 (
        .clk(clk), .rst(rst), .enable(1'b1), .mode(1'b0), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
        .out_ready(1'b1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the output register should hold, and the
    // channel most recently granted.
    int         m_valid;
    int         m_data;
    int         m_chan;
    int         m_last;
    logic [7:0] obs_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle with the inputs currently applied: predict the grant,
    // check in_ready mid-cycle, advance the model at the edge, then check
    // the registered outputs just after it.
    task automatic tick();
        bit         found;
        bit         ld;
        int         g;
        logic [7:0] exp_ready;
        found = 1'b0;
        g     = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < c_N && in_valid[sel]) begin
                found = 1'b1;
                g     = int'(sel);
            end
        end else begin
            for (int k = 1; k <= c_N; k++) begin
                int c;
                c = (m_last + k) % c_N;
                if (!found && in_valid[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
        end
        ld        = !rst && enable && (m_valid == 0 || out_ready) && found;
        exp_ready = ld ? 8'(1 << g) : 8'h00;
        #1;
        obs_ready = in_ready;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_last = c_N - 1;
        end else if (ld) begin
            m_data  = int'(in_data[g*c_W +: c_W]);
            m_chan  = g;
            m_valid = 1;
            m_last  = g;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data",  64'(out_data),  64'(m_data));
        check("out_chan",  64'(out_chan),  64'(m_chan));
    endtask

    initial begin
        logic [c_W-1:0] hold_d;
        logic [c_S-1:0] hold_c;
        m_valid = 0; m_data = 0; m_chan = 0; m_last = c_N - 1;
        rst = 1'b1; enable = 1'b1; mode = 1'b0; sel = '0;
        in_data = {$urandom, $urandom}; in_valid = 8'hFF; out_ready = 1'b1;
        sel6 = 3'd7; in_valid6 = 6'h3F;
        in_data6 = {16'h1234, $urandom};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(obs_ready), 64'd0);
        rst = 1'b0; in_valid = '0;

        // Out-of-range fixed select on a 6-channel instance never grants
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sel7_in_ready6",  64'(in_ready6),  64'd0);
            check("sel7_out_valid6", 64'(out_valid6), 64'd0);
        end
        sel6 = 3'd5;
        #1;
        check("sel5_in_ready6", 64'(in_ready6), 64'h20);
        tick();
        check("sel5_out_chan6", 64'(out_chan6),  64'd5);
        check("sel5_out_data6", 64'(out_data6),  64'h12);
        check("sel5_valid6",    64'(out_valid6), 64'd1);

        // Fixed mode basic path
        sel = 3'd5; in_valid = 8'h20; in_data = {$urandom, $urandom};
        in_data[47:40] = 8'hA5;
        tick();
        check("t1_in_ready", 64'(obs_ready), 64'h20);
        check("t1_out_data", 64'(out_data),  64'hA5);
        check("t1_out_chan", 64'(out_chan),  64'd5);
        in_valid = '0;
        tick();

        // Round-robin fairness and wrap from reset
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            check("rr_seq", 64'(out_chan), 64'(i % c_N));
        end

        // Round-robin skip with last_grant = 1
        mode = 1'b0; sel = 3'd1; in_valid = 8'h02;
        tick();
        mode = 1'b1; in_valid = 8'h82;
        tick(); check("skip_a", 64'(out_chan), 64'd7);
        tick(); check("skip_b", 64'(out_chan), 64'd1);
        tick(); check("skip_c", 64'(out_chan), 64'd7);

        // Backpressure: output holds, nothing accepted
        in_valid = 8'hFF; out_ready = 1'b0;
        hold_d = out_data; hold_c = out_chan;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            check("bp_ready", 64'(obs_ready), 64'd0);
            check("bp_data",  64'(out_data),  64'(hold_d));
            check("bp_chan",  64'(out_chan),  64'(hold_c));
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 64'(obs_ready), 64'h01);
        check("bp_release_valid", 64'(out_valid), 64'd1);

        // enable=0: pending word drains, no new grant, pointer frozen
        enable = 1'b0;
        tick();
        check("en0_valid", 64'(out_valid), 64'd0);
        check("en0_ready", 64'(obs_ready), 64'd0);
        tick();
        enable = 1'b1; out_ready = 1'b0;
        tick();
        check("en1_chan", 64'(out_chan), 64'd1);
        tick();

        // Reset while a word is held
        rst = 1'b1;
        tick();
        check("midrst_ready", 64'(obs_ready), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data",  64'(out_data),  64'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check("postrst_chan", 64'(out_chan), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            enable    = ($urandom_range(0, 5) != 0);
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            in_data   = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
Parametrised N-channel, W-bit registered selector with per-channel valid/ready handshake. It has two modes. Fixed mode forwards the channel chosen by sel. Round-robin mode scans all channels fairly. The result is a single registered output stream carrying channel tag out_chan. It sits between the terminal's input sources (keypad, price lookup, card reader, etc.) and the display/transaction datapath, and it supersedes combinational 8:1 selection.

Parameters:
WIDTH, 8, data bits per channel
CHANNELS, 8, number of input channels (2..16)
SEL_W, 3, select/tag width; must equal ceil(log2(CHANNELS))

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
enable  input  1  1 = new grants allowed; 0 = no new grants (held output still drains)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel data valid
in_ready  output  CHANNELS  per-channel accept strobe (combinational, one-hot or zero)
out_data  output  WIDTH  registered selected data
out_chan  output  SEL_W  registered index of the channel that supplied out_data
out_valid  output  1  out_data/out_chan valid
out_ready  input  1  downstream accepts when out_valid & out_ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_data=0, out_chan=0, out_valid=0, in_ready=0. The round-robin pointer last_grant is set to CHANNELS-1, so the first round-robin search starts at channel 0.
- Load condition: load = enable & (~out_valid | out_ready) & grant_found.
- Fixed mode (mode=0):
  - grant_found = (sel < CHANNELS) & in_valid[sel]; the granted channel is sel.
  - sel >= CHANNELS never grants; in_ready stays 0 and out_valid is unaffected.
- Round-robin mode (mode=1):
  - Search order is last_grant+1, last_grant+2, ... modulo CHANNELS, wrapping past CHANNELS-1 to 0.
  - The first channel with in_valid=1 is granted. grant_found = |in_valid.
- Grant and accept:
  - in_ready[g]=1 only in a cycle where load=1; all other bits of in_ready are 0.
  - The transfer on channel g occurs in that same cycle.
- On load, at the next edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - last_grant <= g, in both modes, so a mode switch continues fairly from the last grant.
- Drain: if out_valid & out_ready & ~load, then out_valid <= 0 at the next edge; out_data and out_chan hold their last values.
- Stall: if out_valid & ~out_ready, all output registers hold and in_ready=0.
- Latency and throughput: 1 cycle from accept to out_valid. Sustained throughput is one word per clock when out_ready is held 1.
- enable=0:
  - No grants are made, and last_grant is frozen.
  - A pending output still completes its handshake.
  - When enable returns to 1, operation resumes with no extra cycles.
- mode or sel change: takes effect combinationally in the same cycle. No flush occurs; a held output is unaffected.
- Simultaneous events:
  - Drain and load in the same cycle means back-to-back transfer: out_valid stays 1 and the data is replaced.
  - rst overrides all other inputs.
- Reset mid-operation: a held, unaccepted word is discarded, and in_ready=0 during the reset cycle.
- Round-robin with a single requester: that channel is granted every cycle, with no bubbles.

Test Plan:
1. Fixed mode, basic path: mode=0, sel=5, in_valid=8'h20, in_data ch5=8'hA5, out_ready=1 -> in_ready=8'h20 that cycle; next cycle out_data=8'hA5, out_chan=5, out_valid=1.
2. Fixed mode, invalid select: CHANNELS=6, sel=7, all in_valid=1 -> in_ready=0 and out_valid stays 0 for 10 cycles.
3. Round-robin fairness and wrap: mode=1, in_valid=8'hFF held, out_ready=1, starting from reset -> out_chan sequence 0,1,...,7,0,1; every channel is granted exactly once per 8 cycles.
4. Round-robin skip: in_valid=8'b1000_0010 with last_grant=1 -> grants 7, then 1, then 7 in successive cycles; channels 0 and 2-6 are never granted.
5. Backpressure: out_ready=0 for 4 cycles after the first load -> out_data and out_chan stable, in_ready=0; when out_ready rises, the next word loads in the same cycle and out_valid stays 1.
6. Enable and reset: enable=0 with out_valid=1 -> the word drains when out_ready=1 and out_valid falls, with no new grant. Then rst=1 asserted while out_valid=1 with out_ready=0 -> the next cycle shows out_valid=0 and out_data=0, and the next round-robin grant is channel 0.
